// File: rtl/tetris_game_fsm.sv
// Top-level game sequencer: idle/spawn/fall/clear/pause/over, with an internal gravity timer
// whose period shrinks with level, plus saturating line and level bookkeeping.
module tetris_game_fsm #(
  parameter int unsigned GRAV_W          = 16,
  parameter int unsigned GRAV_INIT       = 1000,
  parameter int unsigned GRAV_STEP       = 50,
  parameter int unsigned GRAV_MIN        = 100,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned LINES_W         = 10
) (
  input  logic               in_clka,
  input  logic               restart,
  input  logic               start,
  input  logic               pause,
  input  logic               placed,
  input  logic               game_over,
  input  logic               clear_done,
  input  logic [2:0]         lines_cleared,
  output logic [2:0]         state,
  output logic               spawn_req,
  output logic               drop_tick,
  output logic               clear_req,
  output logic [LEVEL_W-1:0] level,
  output logic [LINES_W-1:0] line_count
);

  localparam int unsigned PW    = GRAV_W + LEVEL_W;
  localparam int unsigned REM_W = $clog2(LINES_PER_LEVEL + 4);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSpawn  = 3'd1,
    StFall   = 3'd2,
    StClear  = 3'd3,
    StOver   = 3'd4,
    StPaused = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [GRAV_W-1:0]  cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [REM_W-1:0]   rem_q, rem_d, rem_sum;
  logic               tick_q, tick_d, spawn_q, clear_q;
  logic [PW-1:0]      dec_w, period_w;
  logic [LINES_W:0]   line_sum;
  logic [2:0]         add_w;
  logic               wrap, lvl_up;

  // Wide arithmetic so a large level never wraps the period below the floor.
  always_comb begin : p_period
    dec_w = PW'(level_q) * PW'(GRAV_STEP);
    if (dec_w >= PW'(GRAV_INIT) || (PW'(GRAV_INIT) - dec_w) < PW'(GRAV_MIN)) begin
      period_w = PW'(GRAV_MIN);
    end else begin
      period_w = PW'(GRAV_INIT) - dec_w;
    end
    wrap = (PW'(cnt_q) == period_w - PW'(1));
  end

  always_comb begin : p_counts
    add_w    = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    line_sum = {1'b0, lines_q} + (LINES_W + 1)'(add_w);
    rem_sum  = rem_q + REM_W'(add_w);
    lvl_up   = (rem_sum >= REM_W'(LINES_PER_LEVEL));
  end

  always_comb begin : p_next
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    level_d = level_q;
    lines_d = lines_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StSpawn;
      end
      StSpawn: begin
        if (game_over) begin
          state_d = StOver;
        end else begin
          state_d = StFall;
          cnt_d   = '0;
        end
      end
      StFall: begin
        if (game_over) begin
          state_d = StOver;
        end else if (placed) begin
          state_d = StClear;
        end else if (pause) begin
          state_d = StPaused;
        end else if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + GRAV_W'(1);
        end
      end
      StPaused: begin
        if (pause) state_d = StFall;
      end
      StClear: begin
        if (game_over) begin
          state_d = StOver;
        end else if (clear_done) begin
          state_d = StSpawn;
          lines_d = line_sum[LINES_W] ? '1 : line_sum[LINES_W-1:0];
          rem_d   = lvl_up ? rem_sum - REM_W'(LINES_PER_LEVEL) : rem_sum;
          if (lvl_up && level_q != '1) level_d = level_q + LEVEL_W'(1);
        end
      end
      StOver: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (restart) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= '0;
      lines_q <= '0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      spawn_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      lines_q <= lines_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      spawn_q <= (state_d == StSpawn);
      clear_q <= (state_d == StClear);
    end
  end

  assign state      = state_q;
  assign spawn_req  = spawn_q;
  assign drop_tick  = tick_q;
  assign clear_req  = clear_q;
  assign level      = level_q;
  assign line_count = lines_q;

endmodule

// File: doc/tetris_game_fsm.md
# tetris_game_fsm

Parametrised successor to the main game FSM. Sequences a game through idle, piece spawn, gravity fall, line clear, pause and game-over states. Generates the gravity drop tick internally from a level-dependent period, and handshakes with the spawner and line-clear units. Tracks total lines cleared and the current level. Sits at the top of the control path and drives the piece-movement, spawn and clear datapaths.

## Interface
Parameters:
- GRAV_W, 16: width of gravity counter and period arithmetic
- GRAV_INIT, 1000: drop period in cycles at level 0
- GRAV_STEP, 50: period reduction per level
- GRAV_MIN, 100: floor on drop period; must be ≥1 and ≤ GRAV_INIT
- LINES_PER_LEVEL, 10: lines per level-up; must be ≥4
- LEVEL_W, 4: level width; level saturates at 2^LEVEL_W−1
- LINES_W, 10: line-count width; count saturates at 2^LINES_W−1

Ports:
- in_clka, input, 1: single system clock; all state changes on its rising edge
- restart, input, 1: synchronous active-high reset
- start, input, 1: begin a game (sampled in IDLE)
- pause, input, 1: single-cycle toggle request
- placed, input, 1: active piece has locked
- game_over, input, 1: spawn collision or top-out
- clear_done, input, 1: clear unit finished; qualifies lines_cleared
- lines_cleared, input, 3: rows removed (0–4; values >4 clamp to 4)
- state, output, 3: IDLE=0, SPAWN=1, FALL=2, CLEAR=3, OVER=4, PAUSED=5
- spawn_req, output, 1: high exactly while in SPAWN
- drop_tick, output, 1: one-cycle gravity pulse
- clear_req, output, 1: level, high while in CLEAR
- level, output, LEVEL_W: current level
- line_count, output, LINES_W: total lines cleared

## Operation
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- **Reset:** restart=1 puts the block in IDLE on the next edge, from any state, overriding every other input. Reset values:
  - state=0, level=0, line_count=0
  - spawn_req=0, drop_tick=0, clear_req=0
  - gravity counter=0, level remainder=0
- **Priority in SPAWN, FALL, CLEAR:** restart > game_over > all else. game_over=1 in any of these states moves to OVER.
- **IDLE:** start=1 → SPAWN. All other inputs are ignored.
- **SPAWN:** lasts one cycle with spawn_req=1, then goes to FALL. The gravity counter is zeroed on entry to FALL from SPAWN.
- **FALL:** the gravity counter increments each cycle.
  - When counter == period−1: drop_tick=1 on the next cycle and the counter returns to 0.
  - placed=1 → CLEAR, with priority over gravity. No drop_tick is issued for that wrap.
  - pause=1 (and placed=0) → PAUSED.
- **PAUSED:** the counter is frozen. pause=1 → FALL with the counter value preserved. placed and game_over are ignored.
- **CLEAR:** clear_req is held high until clear_done=1. Then, in the same update:
  - line_count += clamp(lines_cleared), saturating.
  - The remainder accumulates the same amount. If the remainder reaches ≥ LINES_PER_LEVEL, it is reduced by LINES_PER_LEVEL and level is incremented, saturating. At most one level-up per clear.
  - Next state is SPAWN.
  - lines_cleared=0 is legal: counts are unchanged and the block still goes to SPAWN.
- **OVER:** sticky. Only restart exits. level and line_count hold their final values.
- **Period:** max(GRAV_INIT − level·GRAV_STEP, GRAV_MIN).
  - Computed at GRAV_W+LEVEL_W width, with no underflow wrap.
  - A new level's period takes effect at the next counter wrap or the next FALL entry.
- Unused encodings 6 and 7 go to IDLE on the next edge.

## Timing
- start sampled at edge k → state=SPAWN after edge k, FALL after edge k+1.
- First drop_tick after entering FALL occurs in the period-th FALL cycle. Subsequent ticks follow every period cycles.
- placed sampled at edge k → state=CLEAR and clear_req=1 after edge k.
- clear_done sampled at edge k → counts updated and state=SPAWN after edge k. clear_req=0 from that cycle.
- Pause latency is one cycle. Time spent in PAUSED does not count toward gravity.
- restart latency is one cycle to all-zero outputs.

## Test plan
- **Reset and start** (GRAV_INIT=8, GRAV_MIN=2, GRAV_STEP=2): assert restart for 2 cycles → every output is 0. Pulse start → state 1 for exactly one cycle, then 2. drop_tick every 8 cycles.
- **Lock and clear:** in FALL, pulse placed → state 3, clear_req=1 held through a 5-cycle wait. Then clear_done with lines_cleared=3 → line_count=3, state 1 next cycle, then 2.
- **Level-up and period floor** (LINES_PER_LEVEL=4): clears of 4,4,4,4 → level 1,2,3,4 and line_count=16. Period goes 8→6→4→2→2. A clear of lines_cleared=7 adds 4.
- **Pause:** pause at counter=5 → state 5; hold 20 cycles with no drop_tick. Pause again → state 2, and the next drop_tick follows 3 cycles later.
- **Simultaneous events:** placed on the wrap cycle → no drop_tick, state 3. game_over together with placed in FALL → state 4.
- **Game over and restart:** game_over in SPAWN → state 4; start ignored while in OVER. restart mid-CLEAR → IDLE with level=0 and line_count=0.
